// File: rtl/prg_writer.sv
// Buffered PRG/ROM download writer: FIFO between downloader and SDRAM slot port.
// Optional end-of-program pointer fixup enabled by defining PRG_WRITER_PTR_FIXUP_EN.
module prg_writer #(
  parameter int unsigned FIFO_DEPTH     = 16,
  parameter logic [24:0] PRG_START_ADDR = 25'h8241,
  parameter logic [24:0] PTR_PROGND     = 25'h81BB
) (
  input  logic        clk,
  input  logic        res_n,
  input  logic        ena,
  input  logic        in_busy,
  input  logic        in_wr,
  input  logic [24:0] in_addr,
  input  logic [7:0]  in_data,
  output logic        out_wr,
  output logic [24:0] out_addr,
  output logic [7:0]  out_data,
  output logic        busy,
  output logic        overflow,
  output logic [24:0] prg_end
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned PW = AW + 1;

  typedef struct packed {
    logic [24:0] addr;
    logic [7:0]  data;
  } entry_t;

  typedef enum logic [2:0] {IDLE, DRAIN, PTR_LO, PTR_HI, DONE} state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  entry_t        mem_q [FIFO_DEPTH];
  entry_t        rd_entry;
  logic          in_busy_q;
  logic          out_wr_q, out_wr_d;
  logic [24:0]   out_addr_q, out_addr_d;
  logic [7:0]    out_data_q, out_data_d;
  logic          busy_q, busy_d;
  logic          overflow_q, overflow_d;
  logic          full_c, empty_c, pop_c, push_c, busy_rise_c;

`ifdef PRG_WRITER_PTR_FIXUP_EN
  logic [24:0]   max_addr_q, max_addr_d;
  logic          seen_prg_q, seen_prg_d;
  logic [24:0]   prg_end_q, prg_end_d;
  logic [24:0]   ptr_c;
`endif

  assign empty_c     = (wptr_q == rptr_q);
  assign full_c      = (wptr_q[PW-1] != rptr_q[PW-1]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign pop_c       = (state_q == DRAIN) && ena && !empty_c;
  // A full FIFO still accepts a byte when a slot frees the head in the same cycle.
  assign push_c      = in_wr && (!full_c || pop_c);
  assign busy_rise_c = in_busy && !in_busy_q;
  assign rd_entry    = mem_q[rptr_q[AW-1:0]];
  assign wptr_d      = wptr_q + PW'(push_c);
  assign rptr_d      = rptr_q + PW'(pop_c);

  // Next state and registered-output values; outputs only move on slot strobes.
  always_comb begin
    state_d    = state_q;
    out_wr_d   = out_wr_q;
    out_addr_d = out_addr_q;
    out_data_d = out_data_q;
    overflow_d = overflow_q;
`ifdef PRG_WRITER_PTR_FIXUP_EN
    max_addr_d = max_addr_q;
    seen_prg_d = seen_prg_q;
    prg_end_d  = prg_end_q;
    ptr_c      = max_addr_q + 25'd1;
`endif

    if (ena) out_wr_d = 1'b0;

    case (state_q)
      IDLE: ;
      DRAIN: begin
        if (pop_c) begin
          out_wr_d   = 1'b1;
          out_addr_d = rd_entry.addr;
          out_data_d = rd_entry.data;
        end else if (!in_busy && empty_c) begin
`ifdef PRG_WRITER_PTR_FIXUP_EN
          state_d = seen_prg_q ? PTR_LO : DONE;
`else
          state_d = DONE;
`endif
        end
      end
`ifdef PRG_WRITER_PTR_FIXUP_EN
      PTR_LO: begin
        if (ena) begin
          out_wr_d   = 1'b1;
          out_addr_d = PTR_PROGND;
          out_data_d = ptr_c[7:0];
          prg_end_d  = ptr_c;
          state_d    = PTR_HI;
        end
      end
      PTR_HI: begin
        if (ena) begin
          out_wr_d   = 1'b1;
          out_addr_d = PTR_PROGND + 25'd1;
          out_data_d = ptr_c[15:8];
          state_d    = DONE;
        end
      end
`endif
      DONE: begin
        if (ena) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (busy_rise_c) begin
      state_d    = DRAIN;
      overflow_d = 1'b0;
`ifdef PRG_WRITER_PTR_FIXUP_EN
      max_addr_d = 25'd0;
      seen_prg_d = 1'b0;
`endif
    end

    if (in_wr && !push_c) overflow_d = 1'b1;

`ifdef PRG_WRITER_PTR_FIXUP_EN
    // Track the highest BASIC-area address accepted into the FIFO.
    if (push_c && (in_addr >= PRG_START_ADDR)) begin
      if (!seen_prg_d || (in_addr > max_addr_d)) max_addr_d = in_addr;
      seen_prg_d = 1'b1;
    end
`endif

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      state_q    <= IDLE;
      wptr_q     <= '0;
      rptr_q     <= '0;
      in_busy_q  <= 1'b0;
      out_wr_q   <= 1'b0;
      out_addr_q <= 25'd0;
      out_data_q <= 8'd0;
      busy_q     <= 1'b0;
      overflow_q <= 1'b0;
`ifdef PRG_WRITER_PTR_FIXUP_EN
      max_addr_q <= 25'd0;
      seen_prg_q <= 1'b0;
      prg_end_q  <= 25'd0;
`endif
    end else begin
      state_q    <= state_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      in_busy_q  <= in_busy;
      out_wr_q   <= out_wr_d;
      out_addr_q <= out_addr_d;
      out_data_q <= out_data_d;
      busy_q     <= busy_d;
      overflow_q <= overflow_d;
`ifdef PRG_WRITER_PTR_FIXUP_EN
      max_addr_q <= max_addr_d;
      seen_prg_q <= seen_prg_d;
      prg_end_q  <= prg_end_d;
`endif
    end
  end

  // Storage needs no reset; the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push_c) mem_q[wptr_q[AW-1:0]] <= '{addr: in_addr, data: in_data};
  end

  assign out_wr   = out_wr_q;
  assign out_addr = out_addr_q;
  assign out_data = out_data_q;
  assign busy     = busy_q;
  assign overflow = overflow_q;

`ifdef PRG_WRITER_PTR_FIXUP_EN
  assign prg_end = prg_end_q;
`else
  logic unused_cfg;
  assign unused_cfg = ^{PRG_START_ADDR, PTR_PROGND};
  assign prg_end    = 25'd0;
`endif

endmodule

// File: doc/prg_writer.md
# prg_writer

Buffered write stage between the PRG/ROM download stream and the SDRAM write port. It queues every downloaded byte in a small FIFO and replays it into SDRAM, one byte per memory slot. After a BASIC program download it writes the end-of-program pointer (little-endian) so the interpreter sees the loaded program. It replaces the direct downloader-to-SDRAM path in the memory source multiplexer and presents one registered write request per slot.

## Interface
- `FIFO_DEPTH`, 16: FIFO entries; power of two, ≥ 4.
- `PRG_START_ADDR`, 25'h8241: first byte of BASIC program area.
- `PTR_PROGND`, 25'h81BB: address of 16-bit end-of-program pointer.

- `clk`  in  1  system clock (sys_clock domain).
- `res_n`  in  1  reset; asynchronous, active-low.
- `ena`  in  1  SDRAM slot strobe, one `clk` cycle per slot (same strobe as CPU slot, z80_ena rate).
- `in_busy`  in  1  download active (level).
- `in_wr`  in  1  byte valid, one-cycle pulse, any cycle.
- `in_addr`  in  25  byte address.
- `in_data`  in  8  byte value.
- `out_wr`  out  1  SDRAM write request, held for one full slot.
- `out_addr`  out  25  write address.
- `out_data`  out  8  write data.
- `busy`  out  1  stage owns SDRAM port; mux selects this stage while high.
- `overflow`  out  1  sticky: byte dropped because FIFO full.
- `prg_end`  out  25  last pointer value written (end address + 1).

## Operation
- FIFO of {addr,data} entries, 33 bits wide; write/read pointers are log2(FIFO_DEPTH)+1 bits; full when the MSBs differ and the low bits are equal.
- Push on `in_wr`. If the FIFO is full and no pop happens in the same cycle, the byte is dropped and `overflow` is set. A push and a pop in the same cycle while full is legal and does not set `overflow`.
- `max_addr` register tracks the highest `in_addr` ≥ PRG_START_ADDR pushed since the download started. `seen_prg` flag is set by any such push.
- Rising edge of `in_busy`: clear `max_addr`, `seen_prg`, `overflow`; set `busy`. The FIFO is not flushed.
- States:
  - IDLE: `busy`=0. Go to DRAIN on rising `in_busy`.
  - DRAIN: on each `ena` with the FIFO non-empty, pop and present the entry. When `in_busy`=0 and the FIFO is empty, go to PTR_LO if `seen_prg`, else DONE.
  - PTR_LO: on `ena`, write `(max_addr+1)[7:0]` to PTR_PROGND. Latch `prg_end`=max_addr+1. Go to PTR_HI.
  - PTR_HI: on `ena`, write `(max_addr+1)[15:8]` to PTR_PROGND+1. Go to DONE.
  - DONE: on the next `ena`, deassert `out_wr`, drop `busy`, go to IDLE.
- Pointer arithmetic is 25-bit; only bits [15:0] are stored. Wrap at 16'hFFFF+1 gives pointer 16'h0000, which is written as-is.
- Rising `in_busy` in any state other than IDLE restarts tracking as above and goes to DRAIN. The FIFO contents are kept.

## Timing
- Reset values: `out_wr`=0, `out_addr`=0, `out_data`=0, `busy`=0, `overflow`=0, `prg_end`=0. FIFO empty, state IDLE.
- Outputs are registered. A pop or pointer write decided at an `ena` cycle appears on the next `clk` edge and is held until the `clk` edge after the following `ena`.
- If that following `ena` pops again, outputs update back-to-back and `out_wr` stays high. Otherwise `out_wr` falls.
- Latency from `in_wr` to `out_wr` with the FIFO empty: first `ena` at or after the cycle following the push, plus 1 `clk`.
- `in_wr` and `ena` in the same cycle with the FIFO empty: the byte is not popped until the next `ena`.
- `busy` rises 1 `clk` after rising `in_busy`. It falls 1 `clk` after the `ena` that ends the last write slot.
- Throughput: 1 byte per `ena`. Sustained input faster than `ena` overflows after FIFO_DEPTH excess bytes.

## Configuration
- `PRG_WRITER_PTR_FIXUP_EN` defined: pointer states PTR_LO/PTR_HI are active as described, and `prg_end` is updated.
- Not defined: DRAIN goes directly to DONE. `max_addr` and `seen_prg` logic are removed. `prg_end` is held at 0. The block is a pure FIFO bridge.

## Test plan
- Single byte (8241,0x3A) with `ena` every 8 clk, then `in_busy` falls. Expect writes in order: 8241←3A, then 81BB←42, then 81BC←82, then `busy`=0 and `prg_end`=8242.
- ROM download only, addresses 0000..00FF. Expect 256 writes in address order, no pointer write, `prg_end`=0.
- Burst of 20 `in_wr` on consecutive clk with FIFO_DEPTH=16 and `ena` idle. Expect `overflow`=1, the first 16 bytes written, bytes 17–20 absent.
- Push and pop in the same cycle while full. Expect `overflow` stays 0 and no byte is lost.
- `res_n` pulsed low during DRAIN. Expect all outputs 0 immediately (asynchronous), FIFO empty, state IDLE.
- Macro undefined, same stimulus as the first case. Expect only the 8241←3A write; no writes to 81BB or 81BC.
